// File: rtl/edge_sched_pkg.sv
// Shared types and helpers for the edge event scheduler: channel FSM states,
// round-robin pick result and the rotating-priority search.
package edge_sched_pkg;

  localparam int unsigned N_CH_MAX     = 8;
  localparam logic [16:0] DEF_HOLD_CYC = 17'd99999;

  typedef enum logic {CH_IDLE, CH_HOLD} ch_state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of pend searching upward from ptr, wrapping at n_ch.
  function automatic rr_pick_t rr_pick(input logic [N_CH_MAX-1:0] pend,
                                       input logic [2:0]          ptr,
                                       input int unsigned         n_ch);
    rr_pick_t    r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < N_CH_MAX; k++) begin
      j = int'(ptr) + k;
      if (j >= n_ch) j = j - n_ch;
      if (k < n_ch && !r.hit && pend[j[2:0]]) begin
        r.hit = 1'b1;
        r.idx = j[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/edge_holdoff_ch.sv
// One scheduler channel: qualifies a raw level with a retrigger hold-off and
// emits a registered 1-cycle event together with the timestamp of the firing edge.
module edge_holdoff_ch
  import edge_sched_pkg::*;
#(
  parameter int unsigned TS_W  = 32,
  parameter int unsigned CNT_W = 17
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             en,
  input  logic             raw,
  input  logic [CNT_W-1:0] hold_cyc,
  input  logic [TS_W-1:0]  ts,
  output logic             evt,
  output logic [TS_W-1:0]  evt_ts
);

  ch_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hc;
  logic             fire;

  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    case (state)
      CH_IDLE: begin
        if (en && raw) begin
          fire      = 1'b1;
          state_nxt = CH_HOLD;
        end
      end
      CH_HOLD: begin
        if (cnt == hc - CNT_W'(1)) state_nxt = CH_IDLE;
      end
      default: state_nxt = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state  <= CH_IDLE;
      cnt    <= '0;
      hc     <= CNT_W'(1);
      evt    <= 1'b0;
      evt_ts <= '0;
    end else begin
      state <= state_nxt;
      evt   <= fire;
      if (fire) begin
        evt_ts <= ts;
        cnt    <= '0;
        // A zero hold-off behaves as one cycle so the channel always re-arms.
        hc     <= (hold_cyc == '0) ? CNT_W'(1) : hold_cyc;
      end else if (state == CH_HOLD) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/edge_event_sched.sv
// Multi-channel edge event scheduler: timestamped hold-off channels, one-deep
// pending slot per channel, round-robin drain onto a valid/ready port.
// Define EDGE_SCHED_SYNC_EN to pass each raw_sig bit through a 2-FF synchronizer.
module edge_event_sched
  import edge_sched_pkg::*;
#(
  parameter  int unsigned N_CH  = 4,
  parameter  int unsigned TS_W  = 32,
  parameter  int unsigned CNT_W = 17,
  parameter  int unsigned OVF_W = 8,
  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk_50M,
  input  logic             arstn,
  input  logic             en,
  input  logic [N_CH-1:0]  raw_sig,
  input  logic [CNT_W-1:0] hold_cyc,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CH_W-1:0]  evt_ch,
  output logic [TS_W-1:0]  evt_ts,
  output logic [OVF_W-1:0] ovf_cnt,
  output logic             ovf_flag
);

  logic [TS_W-1:0]  ts;
  logic [N_CH-1:0]  raw_q;
  logic [N_CH-1:0]  evt;
  logic [TS_W-1:0]  ch_ts [N_CH];
  logic [N_CH-1:0]  pend;
  logic [TS_W-1:0]  ts_q  [N_CH];
  logic [CH_W-1:0]  ptr, ptr_nxt, sel;
  rr_pick_t         pick;
  logic             load;
  logic [N_CH-1:0]  grant, drop;
  logic [3:0]       n_drop;
  logic [OVF_W+3:0] ovf_sum;
  logic [OVF_W-1:0] ovf_nxt;

  always_ff @(posedge clk_50M or negedge arstn) begin
    if (!arstn) ts <= '0;
    else        ts <= ts + TS_W'(1);
  end

`ifdef EDGE_SCHED_SYNC_EN
  logic [N_CH-1:0] sync1, sync2;
  always_ff @(posedge clk_50M or negedge arstn) begin
    if (!arstn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_sig;
      sync2 <= sync1;
    end
  end
  always_comb raw_q = sync2;
`else
  always_comb raw_q = raw_sig;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_holdoff_ch #(
      .TS_W  (TS_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk      (clk_50M),
      .arstn    (arstn),
      .en       (en),
      .raw      (raw_q[i]),
      .hold_cyc (hold_cyc),
      .ts       (ts),
      .evt      (evt[i]),
      .evt_ts   (ch_ts[i])
    );
  end

  always_comb begin
    pick  = rr_pick(N_CH_MAX'(pend), 3'(ptr), N_CH);
    sel   = CH_W'(pick.idx);
    load  = ~evt_valid | evt_ready;
    grant = '0;
    if (load && pick.hit) grant[sel] = 1'b1;
    ptr_nxt = (sel == CH_W'(N_CH - 1)) ? '0 : sel + CH_W'(1);
    // A slot being granted this cycle can take the new event without loss.
    drop   = evt & pend & ~grant;
    n_drop = '0;
    for (int unsigned i = 0; i < N_CH; i++) n_drop = n_drop + 4'(drop[i]);
    ovf_sum = (OVF_W+4)'(ovf_cnt) + (OVF_W+4)'(n_drop);
    ovf_nxt = (ovf_sum[OVF_W+3:OVF_W] != '0) ? '1 : ovf_sum[OVF_W-1:0];
  end

  always_ff @(posedge clk_50M or negedge arstn) begin
    if (!arstn) begin
      pend <= '0;
      for (int unsigned i = 0; i < N_CH; i++) ts_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (evt[i] && (!pend[i] || grant[i])) begin
          pend[i] <= 1'b1;
          ts_q[i] <= ch_ts[i];
        end else if (grant[i]) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_50M or negedge arstn) begin
    if (!arstn) begin
      ovf_cnt  <= '0;
      ovf_flag <= 1'b0;
    end else begin
      ovf_cnt  <= ovf_nxt;
      ovf_flag <= ovf_flag | (|drop);
    end
  end

  always_ff @(posedge clk_50M or negedge arstn) begin
    if (!arstn) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_ts    <= '0;
      ptr       <= '0;
    end else if (load) begin
      evt_valid <= pick.hit;
      if (pick.hit) begin
        evt_ch <= sel;
        evt_ts <= ts_q[sel];
        ptr    <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_edge_event_sched.sv
// Randomized scoreboard bench for edge_event_sched against an event-time reference model.
module tb_edge_event_sched;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned TS_W  = 32;
  localparam int unsigned CNT_W = 17;
  localparam int unsigned OVF_W = 8;
  localparam int unsigned CH_W  = 2;

  logic             clk_50M = 1'b0;
  logic             arstn = 1'b0;
  logic             en = 1'b0;
  logic [N_CH-1:0]  raw_sig = '0;
  logic [CNT_W-1:0] hold_cyc = '0;
  logic             evt_valid;
  logic             evt_ready = 1'b0;
  logic [CH_W-1:0]  evt_ch;
  logic [TS_W-1:0]  evt_ts;
  logic [OVF_W-1:0] ovf_cnt;
  logic             ovf_flag;

  always #10 clk_50M = ~clk_50M;

  edge_event_sched #(
    .N_CH  (N_CH),
    .TS_W  (TS_W),
    .CNT_W (CNT_W),
    .OVF_W (OVF_W)
  ) dut (
    .clk_50M   (clk_50M),
    .arstn     (arstn),
    .en        (en),
    .raw_sig   (raw_sig),
    .hold_cyc  (hold_cyc),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_ch    (evt_ch),
    .evt_ts    (evt_ts),
    .ovf_cnt   (ovf_cnt),
    .ovf_flag  (ovf_flag)
  );

  typedef struct {
    int              ch;
    logic [TS_W-1:0] ts;
  } word_t;

  word_t exp_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Reference model: a channel may fire at absolute cycle c once c >= ready_at,
  // after which it is blind until c + max(hold,1) + 1.
  longint          cyc;
  logic [TS_W-1:0] m_ts;
  longint          ready_at [N_CH];
  bit              m_pend   [N_CH];
  logic [TS_W-1:0] m_pts    [N_CH];
  bit              fired    [N_CH];
  logic [TS_W-1:0] fired_ts [N_CH];
  bit              m_valid;
  int              m_ptr;
  int              m_ovf;
  bit              m_flag;
  logic [N_CH-1:0] r1, r2;

  task automatic model_reset();
    cyc = 0; m_ts = '0; m_valid = 0; m_ptr = 0; m_ovf = 0; m_flag = 0;
    r1 = '0; r2 = '0;
    for (int i = 0; i < N_CH; i++) begin
      ready_at[i] = 0; m_pend[i] = 0; m_pts[i] = '0; fired[i] = 0; fired_ts[i] = '0;
    end
    exp_q.delete();
  endtask

  task automatic model_step();
    bit              old_pend [N_CH];
    int              g;
    logic [N_CH-1:0] raw_eff;
    longint          hc;
    old_pend = m_pend;
    g = -1;
`ifdef EDGE_SCHED_SYNC_EN
    raw_eff = r2; r2 = r1; r1 = raw_sig;
`else
    raw_eff = raw_sig;
`endif
    if (!m_valid || evt_ready) begin
      m_valid = 0;
      for (int k = 0; k < N_CH; k++) begin
        int j;
        j = (m_ptr + k) % N_CH;
        if (g < 0 && old_pend[j]) g = j;
      end
      if (g >= 0) begin
        m_valid = 1;
        exp_q.push_back('{ch: g, ts: m_pts[g]});
        m_pend[g] = 0;
        m_ptr = (g + 1) % N_CH;
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      if (fired[i]) begin
        if (old_pend[i] && g != i) begin
          if (m_ovf < 255) m_ovf++;
          m_flag = 1;
        end else begin
          m_pend[i] = 1;
          m_pts[i]  = fired_ts[i];
        end
      end
    end
    for (int i = 0; i < N_CH; i++) begin
      fired[i] = 0;
      if (en && raw_eff[i] && cyc >= ready_at[i]) begin
        fired[i]    = 1;
        fired_ts[i] = m_ts;
        hc          = (hold_cyc == 0) ? 1 : longint'(hold_cyc);
        ready_at[i] = cyc + hc + 1;
      end
    end
    m_ts = m_ts + 1;
    cyc++;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk_50M or negedge arstn);
      if (!arstn) model_reset();
      else        model_step();
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_50M) begin
    check("evt_valid", 64'(evt_valid), 64'(m_valid));
    check("ovf_cnt",   64'(ovf_cnt),   64'(m_ovf));
    check("ovf_flag",  64'(ovf_flag),  64'(m_flag));
    if (evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_word: got ch=%0d ts=%0d expected none at %0t", evt_ch, evt_ts, $time);
      end else begin
        word_t w;
        w = exp_q.pop_front();
        check("evt_ch", 64'(evt_ch), 64'(w.ch));
        check("evt_ts", 64'(evt_ts), 64'(w.ts));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  initial begin
    tick(3);
    arstn = 1'b1;
    // Single pulse with idle output.
    en = 1'b1; evt_ready = 1'b1; hold_cyc = 17'd10;
    tick(5); raw_sig = 4'b0001; tick(1); raw_sig = '0; tick(20);
    // Held level retriggers every hold+1 cycles.
    raw_sig = 4'b0010; tick(40); raw_sig = '0; tick(15);
    // Simultaneous bursts drain in rotating order.
    repeat (2) begin
      raw_sig = 4'b1111; tick(1); raw_sig = '0; tick(15);
    end
    // Stalled consumer: later pulses overflow the pending slot.
    evt_ready = 1'b0; hold_cyc = 17'd2;
    repeat (4) begin
      raw_sig = 4'b0100; tick(1); raw_sig = '0; tick(3);
    end
    tick(5); evt_ready = 1'b1; tick(10);
    // Saturate the overflow counter, then reset.
    evt_ready = 1'b0; hold_cyc = '0; raw_sig = 4'b1111; tick(200);
    raw_sig = '0; tick(3);
    arstn = 1'b0; tick(2); arstn = 1'b1; evt_ready = 1'b1; tick(5);
    // Reset while a channel is in hold-off with a word pending.
    evt_ready = 1'b0; hold_cyc = 17'd50;
    raw_sig = 4'b0001; tick(1); raw_sig = 4'b0010; tick(1); raw_sig = '0; tick(4);
    #4 arstn = 1'b0;
    #1 check("reset_valid", 64'(evt_valid), 64'd0);
    check("reset_ovf", 64'(ovf_cnt), 64'd0);
    tick(2); arstn = 1'b1; evt_ready = 1'b1; tick(10);
    raw_sig = 4'b0001; tick(1); raw_sig = '0; tick(10);
    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      en        = ($urandom % 8) != 0;
      evt_ready = ($urandom % 4) != 0;
      hold_cyc  = CNT_W'($urandom % 9);
      for (int i = 0; i < N_CH; i++) raw_sig[i] = ($urandom % 6) == 0;
      if (($urandom % 1000) == 0) begin
        arstn = 1'b0; tick(1); arstn = 1'b1;
      end else begin
        tick(1);
      end
    end
    raw_sig = '0; evt_ready = 1'b1; tick(30);
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
